// File: rtl/muldiv_unit_if.sv
// Register-file side handshake of the iterative multiply/divide unit.
// The core drives the request half; the unit drives busy, strobe and write-back data.
interface muldiv_unit_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      start_i;
    logic [2:0]                op_i;
    logic [XLEN-1:0]           operand_a_i;
    logic [XLEN-1:0]           operand_b_i;
    logic [REG_ADDR_WIDTH-1:0] rd_i;
    logic                      flush_i;
    logic                      busy_o;
    logic                      valid_o;
    logic [XLEN-1:0]           result_o;
    logic [REG_ADDR_WIDTH-1:0] rd_o;

    modport master (
        output start_i, op_i, operand_a_i, operand_b_i, rd_i, flush_i,
        input  busy_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, operand_a_i, operand_b_i, rd_i, flush_i,
        output busy_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: one shift-add or restoring-subtract step per clock
// on magnitudes, with the sign applied when the result register is loaded.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state, state_nxt;
    logic [2:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      neg_q;
    logic [XLEN-1:0]           opnd_q;
    logic [XLEN-1:0]           hi_q, lo_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [XLEN-1:0]           result_q;
    logic [REG_ADDR_WIDTH-1:0] rd_out_q;

    function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] sign_fix_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Request decode: signedness, magnitudes and the cases that skip iteration
    logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_start;
    logic            div_by_zero, overflow, special, start_fire, last;
    logic [XLEN-1:0] a_abs, b_abs, special_res;

    assign is_div      = bus.op_i[2];
    assign a_signed    = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
    assign b_signed    = is_div ? ~bus.op_i[0] : ~bus.op_i[1];
    assign a_neg       = a_signed & bus.operand_a_i[XLEN-1];
    assign b_neg       = b_signed & bus.operand_b_i[XLEN-1];
    assign a_abs       = sign_fix(bus.operand_a_i, a_neg);
    assign b_abs       = sign_fix(bus.operand_b_i, b_neg);
    // Remainder follows the dividend's sign; everything else follows the product of signs
    assign neg_start   = (is_div & bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_by_zero = is_div & (bus.operand_b_i == '0);
    assign overflow    = is_div & ~bus.op_i[0] & (bus.operand_b_i == '1)
                       & (bus.operand_a_i == {1'b1, {(XLEN-1){1'b0}}});
    assign special     = div_by_zero | overflow;
    assign special_res = div_by_zero ? (bus.op_i[1] ? bus.operand_a_i : '1)
                                     : (bus.op_i[1] ? '0 : bus.operand_a_i);
    assign start_fire  = (state == IDLE) & bus.start_i & ~bus.flush_i;
    assign last        = (cnt_q == CNT_W'(XLEN-1));

    // One iteration: {hi,lo} is the product accumulator or the remainder/quotient pair
    logic [XLEN-1:0]   addend, hi_nxt, lo_nxt, final_res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod;

    assign addend   = lo_q[0] ? opnd_q : '0;
    assign mul_sum  = {1'b0, hi_q} + {1'b0, addend};
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};

    always_comb begin
        hi_nxt = mul_sum[XLEN:1];
        lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_nxt = div_diff[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_sh[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign prod = sign_fix_wide({hi_nxt, lo_nxt}, neg_q);

    always_comb begin
        final_res = prod[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:         final_res = prod[XLEN-1:0];
            3'b100, 3'b101: final_res = sign_fix(lo_nxt, neg_q);
            3'b110, 3'b111: final_res = sign_fix(hi_nxt, neg_q);
            default:        final_res = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_fire) state_nxt = special ? DONE : CALC;
            CALC:    if (bus.flush_i) state_nxt = IDLE;
                     else if (last)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (start_fire) begin
            op_q   <= bus.op_i;
            rd_q   <= bus.rd_i;
            neg_q  <= neg_start;
            cnt_q  <= '0;
            hi_q   <= '0;
            opnd_q <= is_div ? b_abs : a_abs;
            lo_q   <= is_div ? a_abs : b_abs;
            if (special) begin
                result_q <= special_res;
                rd_out_q <= bus.rd_i;
            end
        end else if (state == CALC && !bus.flush_i) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                result_q <= final_res;
                rd_out_q <= rd_q;
            end
        end
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;
endmodule
